clk_div_multi: RTL and testbench

- Multi-channel, parametrised clock-enable generator. It is the successor to the single fixed-rate toggle divider.
- Each channel divides the system clock by a run-time-loadable divisor and produces two outputs: a one-cycle tick (clock enable) and a 50% square wave.
- Divisor changes are glitch-free, and a phase-align input restarts all channels together.
- Feeds display scanning, debouncers and timers in the lab top levels.

---
 rtl/clk_div_pkg.sv | 27 ++
 rtl/clk_div_chan.sv | 134 +++++++++++++
 rtl/clk_div_multi.sv | 60 ++++++
 tb/tb_clk_div_multi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the multi-channel clock-enable generator.
//   CNT_W_DEF   : default counter / divisor width
//   DEF_DIV_DEF : default reset divisor
//   CLK_HZ      : reference system clock frequency (50 MHz)
//   hz_to_div() : divisor that gives a square wave of the requested frequency
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF   = 32'd32;
   localparam int unsigned DEF_DIV_DEF = 32'd50_000;
   localparam int unsigned CLK_HZ      = 32'd50_000_000;

   // sq period is 2 x divisor, so the divisor is half the cycles per sq period.
   // A request for 0 Hz yields divisor 0, which parks the channel.
   function automatic logic [31:0] hz_to_div(input logic [31:0] hz);
      logic [31:0] div_s;
      if (hz == 32'd0) begin
         div_s = 32'd0;
      end else begin
         div_s = CLK_HZ / (32'd2 * hz);
      end
      return div_s;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active divisor, shadow divisor, pending flag,
// registered tick (one cycle per period) and registered 50% square wave.
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   run            : channel is counting this cycle (global and channel enable)
//   sync           : restart the counter, clear sq, apply any pending divisor
//   ld, ld_div     : load strobe and new divisor for this channel
//   tick, sq, busy : registered outputs
// -----------------------------------------------------------------------------
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int          CNT_W   = CNT_W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             sync,
   input  logic             ld,
   input  logic [CNT_W-1:0] ld_div,
   output logic             tick,
   output logic             sq,
   output logic             busy
);

   localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   logic [CNT_W-1:0] shadow_nx_s;
   logic [CNT_W-1:0] div_m1_s;
   logic             pend_s;
   logic             wrap_s;
   logic             stopped_s;

   // Next-state logic: sync, then immediate apply, then hold, then counting.
   always_comb begin
      // A load this cycle is folded in first, so every later decision
      // (sync, immediate apply, wrap apply) sees the newest divisor.
      shadow_nx_s = ld ? ld_div : shadow_q;
      pend_s      = ld | busy_q;
      div_m1_s    = cur_div_q - ONE_C;     // wraps to all-ones for 0, guarded by stopped_s
      wrap_s      = (cnt_q == div_m1_s);
      stopped_s   = (cur_div_q == ZERO_C);

      cnt_d     = cnt_q;
      cur_div_d = cur_div_q;
      shadow_d  = shadow_nx_s;
      busy_d    = busy_q;
      tick_d    = 1'b0;
      sq_d      = sq_q;

      if (sync) begin
         cnt_d  = ZERO_C;
         sq_d   = 1'b0;
         busy_d = 1'b0;
         if (pend_s) begin
            cur_div_d = shadow_nx_s;
         end else begin
            cur_div_d = cur_div_q;
         end
      end else if (pend_s && (stopped_s || !run)) begin
         // Nothing is mid-period, so the new divisor can take over at once.
         cur_div_d = shadow_nx_s;
         busy_d    = 1'b0;
         cnt_d     = ZERO_C;
         if (shadow_nx_s == ZERO_C) begin
            sq_d = 1'b0;
         end else begin
            sq_d = sq_q;
         end
      end else if (!run) begin
         cnt_d = cnt_q;
         sq_d  = sq_q;
      end else if (stopped_s) begin
         cnt_d = ZERO_C;
         sq_d  = 1'b0;
      end else if (wrap_s) begin
         cnt_d  = ZERO_C;
         tick_d = 1'b1;
         sq_d   = ~sq_q;
         if (pend_s) begin
            // Period boundary: swap divisors here so no period is cut short.
            cur_div_d = shadow_nx_s;
            busy_d    = 1'b0;
            if (shadow_nx_s == ZERO_C) begin
               tick_d = 1'b0;
               sq_d   = 1'b0;
            end else begin
               tick_d = 1'b1;
            end
         end else begin
            busy_d = 1'b0;
         end
      end else begin
         cnt_d  = cnt_q + ONE_C;
         busy_d = pend_s;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= ZERO_C;
         cur_div_q <= DEF_DIV_C;
         shadow_q  <= DEF_DIV_C;
         busy_q    <= 1'b0;
         tick_q    <= 1'b0;
         sq_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         cur_div_q <= cur_div_d;
         shadow_q  <= shadow_d;
         busy_q    <= busy_d;
         tick_q    <= tick_d;
         sq_q      <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;
   assign busy = busy_q;

endmodule

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel clock-enable generator. Each channel divides clk by its own
// run-time loadable divisor and emits a one-cycle tick and a 50% square wave.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   en, ch_en         : global and per-channel enables
//   sync              : restart all channels in the same cycle
//   ld_valid, ld_ch,
//   ld_div            : divisor load strobe, target channel, new divisor
//   tick, sq, busy    : per-channel registered outputs
// -----------------------------------------------------------------------------
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int          NUM_CH  = 4,
   parameter int          CNT_W   = CNT_W_DEF,
   parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync,
   input  logic              ld_valid,
   input  logic [3:0]        ld_ch,
   input  logic [CNT_W-1:0]  ld_div,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic [NUM_CH-1:0] busy
);

   logic [NUM_CH-1:0] ld_hit_s;
   logic [NUM_CH-1:0] run_s;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g = g + 1) begin : g_ch
         // Out-of-range ld_ch matches no channel, so such loads are dropped.
         assign ld_hit_s[g] = ld_valid & (ld_ch == 4'(g));
         assign run_s[g]    = en & ch_en[g];

         clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
         ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .run    (run_s[g]),
            .sync   (sync),
            .ld     (ld_hit_s[g]),
            .ld_div (ld_div),
            .tick   (tick[g]),
            .sq     (sq[g]),
            .busy   (busy[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Self-checking bench: directed reset/load sequence followed by randomized
// traffic, all compared each cycle against a behavioural model that tracks
// elapsed cycles in the current period.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;
   import clk_div_pkg::*;

   localparam int NCH  = 2;
   localparam int CW   = 8;
   localparam int DDIV = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [NCH-1:0] ch_en;
   logic           sync;
   logic           ld_valid;
   logic [3:0]     ld_ch;
   logic [CW-1:0]  ld_div;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] sq;
   logic [NCH-1:0] busy;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   int unsigned m_div  [NCH];
   int unsigned m_shd  [NCH];
   int unsigned m_pos  [NCH];   // cycles elapsed in the current period
   bit          m_pend [NCH];
   bit          m_tk   [NCH];
   bit          m_sq   [NCH];

   always #5 clk = ~clk;

   clk_div_multi #(
      .NUM_CH  (NCH),
      .CNT_W   (CW),
      .DEF_DIV (DDIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .ch_en    (ch_en),
      .sync     (sync),
      .ld_valid (ld_valid),
      .ld_ch    (ld_ch),
      .ld_div   (ld_div),
      .tick     (tick),
      .sq       (sq),
      .busy     (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one clock edge worth of behaviour using the inputs present at the edge.
   function automatic void model_step();
      for (int i = 0; i < NCH; i++) begin
         bit running;
         running = en && ch_en[i];
         if (rst) begin
            m_div[i] = DDIV; m_shd[i] = DDIV; m_pend[i] = 1'b0;
            m_pos[i] = 0; m_tk[i] = 1'b0; m_sq[i] = 1'b0;
         end else begin
            if (ld_valid && (int'(ld_ch) == i)) begin
               m_shd[i]  = ld_div;
               m_pend[i] = 1'b1;
            end
            if (sync) begin
               if (m_pend[i]) begin
                  m_div[i] = m_shd[i];
                  m_pend[i] = 1'b0;
               end
               m_pos[i] = 0; m_tk[i] = 1'b0; m_sq[i] = 1'b0;
            end else if (m_pend[i] && (m_div[i] == 0 || !running)) begin
               m_div[i] = m_shd[i];
               m_pend[i] = 1'b0;
               m_pos[i] = 0; m_tk[i] = 1'b0;
               if (m_div[i] == 0) m_sq[i] = 1'b0;
            end else if (!running) begin
               m_tk[i] = 1'b0;
            end else if (m_div[i] == 0) begin
               m_pos[i] = 0; m_tk[i] = 1'b0; m_sq[i] = 1'b0;
            end else begin
               m_pos[i]++;
               if (m_pos[i] == m_div[i]) begin
                  m_pos[i] = 0; m_tk[i] = 1'b1; m_sq[i] = !m_sq[i];
                  if (m_pend[i]) begin
                     m_div[i] = m_shd[i];
                     m_pend[i] = 1'b0;
                     if (m_div[i] == 0) begin
                        m_tk[i] = 1'b0; m_sq[i] = 1'b0;
                     end
                  end
               end else begin
                  m_tk[i] = 1'b0;
               end
            end
         end
      end
   endfunction

   task automatic cycle();
      logic [NCH-1:0] et, es, eb;
      @(posedge clk);
      model_step();
      #1;
      for (int i = 0; i < NCH; i++) begin
         et[i] = m_tk[i]; es[i] = m_sq[i]; eb[i] = m_pend[i];
      end
      check_eq("tick", 32'(tick), 32'(et));
      check_eq("sq",   32'(sq),   32'(es));
      check_eq("busy", 32'(busy), 32'(eb));
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; ch_en = '1; sync = 1'b0;
      ld_valid = 1'b0; ld_ch = 4'd0; ld_div = 8'd0;

      check_eq("hz_to_div", hz_to_div(32'd1000), 32'd25000);

      repeat (3) cycle();
      check_eq("rst_tick", 32'(tick), 32'd0);
      check_eq("rst_sq",   32'(sq),   32'd0);

      // Directed: release reset, load ch1 with 3 in cycle 2.
      rst = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         ld_valid = (k == 2);
         ld_ch    = 4'd1;
         ld_div   = 8'd3;
         cycle();
         if (k == 4 || k == 8 || k == 12) check_eq("t0_period", 32'(tick[0]), 32'd1);
         if (k == 3) check_eq("t0_quiet", 32'(tick[0]), 32'd0);
         if (k == 4) check_eq("sq0_rise", 32'(sq[0]), 32'd1);
         if (k == 8) check_eq("sq0_fall", 32'(sq[0]), 32'd0);
         if (k == 2 || k == 3) check_eq("busy1_pend", 32'(busy[1]), 32'd1);
         if (k == 4) check_eq("busy1_clr", 32'(busy[1]), 32'd0);
         if (k == 7 || k == 10 || k == 13) check_eq("t1_newdiv", 32'(tick[1]), 32'd1);
      end
      ld_valid = 1'b0;

      // Directed: out-of-range load leaves everything alone.
      ld_valid = 1'b1; ld_ch = 4'd7; ld_div = 8'd1;
      cycle();
      ld_valid = 1'b0;
      check_eq("ld_oob_busy", 32'(busy), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 199) == 0);
         en       = ($urandom_range(0, 15) != 0);
         for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
         sync     = ($urandom_range(0, 63) == 0);
         ld_valid = ($urandom_range(0, 9) == 0);
         ld_ch    = 4'($urandom_range(0, NCH - 1));
         if ($urandom_range(0, 3) == 0) ld_ch = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0:       ld_div = 8'd0;
            1:       ld_div = 8'd1;
            2:       ld_div = 8'hff;
            default: ld_div = 8'($urandom_range(2, 7));
         endcase
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
